cms_axis_downsizer: RTL and testbench
=====================================

// Module: cms_axis_downsizer
// PURPOSE
//  AXI-Stream width converter downstream of continuous_monitoring_system.
//  Accepts 96-bit trace items ({pc, instr}) and emits them as 32-bit beats
//  towards the DMA/FIFO path. Preserves packet boundaries: input tlast
//  becomes tlast on the final sub-beat only.
// PARAMETERS
//  IN_WIDTH   96  input item width; must be an integer multiple of OUT_WIDTH
//  OUT_WIDTH  32  output beat width
//  RATIO      IN_WIDTH/OUT_WIDTH (localparam, 3 by default); beats per item
// PORTS
//  clk            in   1          single clock, rising edge
//  rst_n          in   1          asynchronous, active-low reset
//  S_AXIS_tvalid  in   1          input item valid
//  S_AXIS_tready  out  1          input item accepted when tvalid&&tready
//  S_AXIS_tdata   in   IN_WIDTH   trace item
//  S_AXIS_tlast   in   1          last item of packet
//  M_AXIS_tvalid  out  1          output beat valid
//  M_AXIS_tready  in   1          downstream ready
//  M_AXIS_tdata   out  OUT_WIDTH  output beat
//  M_AXIS_tlast   out  1          last beat of packet
// BEHAVIOUR
//  - State: buf[IN_WIDTH], buf_last, lane[$clog2(RATIO)], full. Two states: EMPTY (full=0), BUSY (full=1).
//  - Reset: full=0, lane=0, buf=0, buf_last=0 -> M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0.
//  - S_AXIS_tready = !full || (M_AXIS_tready && lane==RATIO-1); combinational, no dependence on S_AXIS_tvalid.
//  - EMPTY + input handshake: buf<=tdata, buf_last<=tlast, lane<=0, full<=1. First output beat valid next cycle (latency 1).
//  - BUSY: M_AXIS_tvalid=1; M_AXIS_tdata=buf[lane*OUT_WIDTH +: OUT_WIDTH] (lane 0 = LSBs, sent first).
//    M_AXIS_tlast = buf_last && lane==RATIO-1.
//  - BUSY + output handshake, lane<RATIO-1: lane<=lane+1.
//  - BUSY + output handshake on lane RATIO-1 with simultaneous input handshake: reload buf, lane<=0, stay BUSY (no bubble).
//    Without input handshake: full<=0.
//  - Sustained throughput: one item per RATIO cycles; output never idles while input is continuously valid.
//  - Stall: while M_AXIS_tvalid && !M_AXIS_tready, M_AXIS_tdata/tlast held stable; lane unchanged.
//  - Input data never dropped; backpressure propagates upstream via S_AXIS_tready=0.
//  - Reset asserted mid-item: partially sent item discarded, outputs return to reset values immediately.
// CONFIGURATION
//  CMS_DOWNSIZER_STATS_EN defined: extra outputs item_count[31:0], packet_count[31:0], stall_count[31:0].
//    item_count++ per input handshake; packet_count++ per input handshake with tlast=1;
//    stall_count++ each cycle M_AXIS_tvalid && !M_AXIS_tready. All reset to 0, wrap 0xFFFFFFFF->0.
//  Not defined: counters and ports absent; datapath identical.
// STRUCTURE
//  Shared package cms_pkg: CMS_ITEM_WIDTH=96, CMS_DMA_WIDTH=32, derived ratio and lane-index width.
//  Sub-module cms_stat_counter (32-bit enable counter, async reset, wrap), instantiated 3x only under CMS_DOWNSIZER_STATS_EN.
// TESTING
//  1. Reset, M ready=1; push 96'h0000_0000_0000_0004_0000_006F tlast=0
//     -> beats 32'h0000006F, 32'h00000004, 32'h00000000, all tlast=0, on 3 consecutive cycles starting 1 cycle after accept.
//  2. Continuous valid, 4 items, last with tlast=1, M ready=1
//     -> 12 back-to-back beats, no gap, tlast only on beat 12; S tready low 2 of every 3 cycles.
//  3. M ready=0 for 5 cycles after beat 1 of an item
//     -> tdata/tlast stable for those 5 cycles, S tready=0, then remaining 2 beats in order.
//  4. Random M ready (50%) and S valid, 1000 items, tlast every 100
//     -> scoreboard: output reassembles to exact input sequence, 10 tlast beats.
//  5. Assert rst_n low after beat 2 of an item -> tvalid=0 asynchronously;
//     after release next item starts at lane 0, no stale beat.
//  6. With CMS_DOWNSIZER_STATS_EN, test 2 plus 5 stall cycles -> item_count=4, packet_count=1, stall_count=5.

Source files
------------

// File: rtl/cms_pkg.sv
// -----------------------------------------------------------------------------
// cms_pkg
// Shared constants for the continuous_monitoring_system trace path.
//   CMS_ITEM_WIDTH : width of one trace item ({pc, instr})
//   CMS_DMA_WIDTH  : width of one beat on the DMA/FIFO side
//   CMS_RATIO      : beats per trace item
//   CMS_LANE_W     : width of a lane index able to count 0..CMS_RATIO-1
//   cms_dsz_state_e: downsizer buffer state (EMPTY / BUSY)
// -----------------------------------------------------------------------------
package cms_pkg;

    // Lane index width; a single-lane converter still needs a 1-bit index
    function automatic int cms_lane_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int CMS_ITEM_WIDTH = 96;
    localparam int CMS_DMA_WIDTH  = 32;
    localparam int CMS_RATIO      = CMS_ITEM_WIDTH / CMS_DMA_WIDTH;
    localparam int CMS_LANE_W     = cms_lane_width(CMS_RATIO);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } cms_dsz_state_e;

endpackage

// File: rtl/cms_stat_counter.sv
// -----------------------------------------------------------------------------
// cms_stat_counter
// 32-bit event counter: increments once per clock while en is high and wraps
// from 0xFFFFFFFF back to 0.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   en    : count enable (one event per cycle)
//   count : current count (registered)
// -----------------------------------------------------------------------------
module cms_stat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Event counter with natural modulo-2^32 wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (en) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/cms_axis_downsizer.sv
// -----------------------------------------------------------------------------
// cms_axis_downsizer
// AXI-Stream width converter: takes IN_WIDTH-bit trace items and sends them as
// RATIO = IN_WIDTH/OUT_WIDTH beats of OUT_WIDTH bits, least-significant lane
// first. Input tlast is carried onto the final beat of the item only.
// IN_WIDTH must be an integer multiple of OUT_WIDTH.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   S_AXIS_tvalid/tready/tdata/tlast : item input
//   M_AXIS_tvalid/tready/tdata/tlast : beat output
//   item_count, packet_count, stall_count : statistics (only when
//       CMS_DOWNSIZER_STATS_EN is defined)
//
// Optional feature macro: CMS_DOWNSIZER_STATS_EN
//   Adds three 32-bit wrapping counters: accepted items, accepted items with
//   tlast, and cycles where an output beat is stalled by the sink.
// -----------------------------------------------------------------------------
module cms_axis_downsizer
    import cms_pkg::*;
#(
    parameter int IN_WIDTH  = CMS_ITEM_WIDTH,
    parameter int OUT_WIDTH = CMS_DMA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tlast,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
    output logic                 M_AXIS_tlast
`ifdef CMS_DOWNSIZER_STATS_EN
    ,
    output logic [31:0]          item_count,
    output logic [31:0]          packet_count,
    output logic [31:0]          stall_count
`endif
);

    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int LANE_W = cms_lane_width(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [LANE_W-1:0] LANE_ZERO = {LANE_W{1'b0}};

    cms_dsz_state_e        state_r;
    logic [IN_WIDTH-1:0]   item_buf_r;
    logic                  item_last_r;
    logic [LANE_W-1:0]     lane_r;
    logic [OUT_WIDTH-1:0]  tdata_r;
    logic                  tlast_r;

    logic                  busy_s;
    logic                  last_lane_s;
    logic                  in_hs_s;
    logic                  out_hs_s;
    logic [LANE_W-1:0]     lane_next_s;

    // Handshake decode; tready opens when empty or when the final lane leaves
    always_comb begin
        busy_s        = (state_r == ST_BUSY);
        last_lane_s   = (lane_r == LAST_LANE);
        lane_next_s   = lane_r + LANE_W'(1'b1);
        S_AXIS_tready = !busy_s || (M_AXIS_tready && last_lane_s);
        in_hs_s       = S_AXIS_tvalid && S_AXIS_tready;
        out_hs_s      = busy_s && M_AXIS_tready;
    end

    // Buffer FSM. The output beat is kept in its own register so tdata/tlast
    // come straight from flops; it is preloaded with the next lane whenever
    // the lane advances. A reload on the final lane skips the EMPTY state so
    // back-to-back items stream without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            item_buf_r  <= {IN_WIDTH{1'b0}};
            item_last_r <= 1'b0;
            lane_r      <= LANE_ZERO;
            tdata_r     <= {OUT_WIDTH{1'b0}};
            tlast_r     <= 1'b0;
        end else if (in_hs_s) begin
            state_r     <= ST_BUSY;
            item_buf_r  <= S_AXIS_tdata;
            item_last_r <= S_AXIS_tlast;
            lane_r      <= LANE_ZERO;
            tdata_r     <= S_AXIS_tdata[OUT_WIDTH-1:0];
            tlast_r     <= S_AXIS_tlast && (LAST_LANE == LANE_ZERO);
        end else if (out_hs_s) begin
            if (last_lane_s) begin
                state_r <= ST_EMPTY;
                lane_r  <= LANE_ZERO;
                tdata_r <= {OUT_WIDTH{1'b0}};
                tlast_r <= 1'b0;
            end else begin
                state_r <= ST_BUSY;
                lane_r  <= lane_next_s;
                tdata_r <= item_buf_r[int'(lane_next_s) * OUT_WIDTH +: OUT_WIDTH];
                tlast_r <= item_last_r && (lane_next_s == LAST_LANE);
            end
        end else begin
            state_r <= state_r;
            lane_r  <= lane_r;
            tdata_r <= tdata_r;
            tlast_r <= tlast_r;
        end
    end

    assign M_AXIS_tvalid = busy_s;
    assign M_AXIS_tdata  = tdata_r;
    assign M_AXIS_tlast  = tlast_r;

`ifdef CMS_DOWNSIZER_STATS_EN
    logic pkt_hs_s;
    logic stall_s;

    // Counter enables
    always_comb begin
        pkt_hs_s = in_hs_s && S_AXIS_tlast;
        stall_s  = busy_s && !M_AXIS_tready;
    end

    cms_stat_counter u_item_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_hs_s),
        .count (item_count)
    );

    cms_stat_counter u_packet_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pkt_hs_s),
        .count (packet_count)
    );

    cms_stat_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_s),
        .count (stall_count)
    );
`endif

endmodule

// File: tb/tb_cms_axis_downsizer.sv
// -----------------------------------------------------------------------------
// tb_cms_axis_downsizer
// Self-checking bench for cms_axis_downsizer. Expected beats come from a
// queue model: every accepted item is split into three 32-bit beats, LSBs
// first, with tlast on the third beat only when the item carried tlast.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_cms_axis_downsizer;

    localparam int NB = 3;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [95:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
`ifdef CMS_DOWNSIZER_STATS_EN
    logic [31:0] item_count;
    logic [31:0] packet_count;
    logic [31:0] stall_count;
`endif

    int    total = 0;
    int    bad   = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    cms_axis_downsizer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .S_AXIS_tvalid (s_valid),
        .S_AXIS_tready (s_ready),
        .S_AXIS_tdata  (s_data),
        .S_AXIS_tlast  (s_last),
        .M_AXIS_tvalid (m_valid),
        .M_AXIS_tready (m_ready),
        .M_AXIS_tdata  (m_data),
        .M_AXIS_tlast  (m_last)
`ifdef CMS_DOWNSIZER_STATS_EN
        ,
        .item_count    (item_count),
        .packet_count  (packet_count),
        .stall_count   (stall_count)
`endif
    );

    // Reference model: an accepted item becomes NB beats, low word first
    function automatic void model_accept(input logic [95:0] d, input logic l);
        beat_t b;
        for (int k = 0; k < NB; k++) begin
            b.d = d[k*32 +: 32];
            b.l = l && (k == NB - 1);
            exp_q.push_back(b);
        end
    endfunction

    function automatic logic [95:0] rand_item();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 96'd0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_valid); end
        if (m_last !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", m_last); end
        if (m_data !== 32'd0) begin bad++; $display("FAIL reset_tdata: got %h want 0", m_data); end
        if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_sready: got %b want 1", s_ready); end
        rst_n = 1'b1;
        next_drive();
    endtask

    task automatic test_single();
        logic [31:0] want [NB];
        want[0] = 32'h0000_006F;
        want[1] = 32'h0000_0004;
        want[2] = 32'h0000_0000;
        s_valid = 1'b1;
        s_data  = 96'h0000_0000_0000_0004_0000_006F;
        s_last  = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        total += 2;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL single_accept: got tready=%b want 1", s_ready); end
        if (m_valid !== 1'b0) begin bad++; $display("FAIL single_latency: got tvalid=%b want 0", m_valid); end
        next_drive();
        s_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            total += 3;
            if (m_valid !== 1'b1) begin bad++; $display("FAIL single_valid%0d: got %b want 1", k, m_valid); end
            if (m_data !== want[k]) begin bad++; $display("FAIL single_data%0d: got %h want %h", k, m_data, want[k]); end
            if (m_last !== 1'b0) begin bad++; $display("FAIL single_last%0d: got %b want 0", k, m_last); end
            next_drive();
        end
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL single_idle: got tvalid=%b want 0", m_valid); end
        next_drive();
    endtask

    task automatic test_back_to_back();
        logic [95:0] items [4];
        beat_t e;
        int sent = 0, beats = 0, low = 0, tl = 0, first = -1, last = -1;
        for (int i = 0; i < 4; i++) items[i] = rand_item();
        exp_q.delete();
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            s_valid = (sent < 4);
            s_data  = items[(sent < 4) ? sent : 3];
            s_last  = (sent == 3);
            @(negedge clk);
            if (m_valid && m_ready) begin
                total++;
                if (!s_ready) low++;
                if (m_last) tl++;
                if (first < 0) first = cyc;
                last = cyc;
                beats++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: got %h with nothing expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        bad++; $display("FAIL b2b_beat: got %h/%b want %h/%b", m_data, m_last, e.d, e.l);
                    end
                end
            end
            if (s_valid && s_ready) begin
                model_accept(items[sent], s_last);
                sent++;
            end
            next_drive();
            if (sent == 4 && exp_q.size() == 0) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        total += 4;
        if (beats !== 12) begin bad++; $display("FAIL b2b_count: got %0d beats want 12", beats); end
        if (last - first !== 11) begin bad++; $display("FAIL b2b_gap: got span %0d want 11", last - first); end
        if (tl !== 1) begin bad++; $display("FAIL b2b_tlast: got %0d tlast beats want 1", tl); end
        if (low !== 8) begin bad++; $display("FAIL b2b_tready: got %0d low cycles want 8", low); end
    endtask

    task automatic test_stall();
        logic [95:0] a, b;
        beat_t e;
        int  after = 0;
        logic b_taken = 1'b0;
        a = rand_item();
        b = rand_item();
        exp_q.delete();
        s_valid = 1'b1; s_data = a; s_last = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        if (s_valid && s_ready) model_accept(a, 1'b1);
        next_drive();
        s_data = b; s_last = 1'b0;
        @(negedge clk);
        total++;
        if (!(m_valid && exp_q.size() > 0 && m_data === exp_q[0].d)) begin
            bad++; $display("FAIL stall_beat0: got %b/%h want beat 0 of item", m_valid, m_data);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        next_drive();
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total += 3;
            if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_valid%0d: got %b want 1", c, m_valid); end
            if (exp_q.size() == 0 || m_data !== exp_q[0].d || m_last !== exp_q[0].l) begin
                bad++; $display("FAIL stall_hold%0d: got %h/%b want held beat 1", c, m_data, m_last);
            end
            if (s_ready !== 1'b0) begin bad++; $display("FAIL stall_sready%0d: got %b want 0", c, s_ready); end
            next_drive();
        end
        m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                total++;
                after++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stall_extra: got %h with nothing expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        bad++; $display("FAIL stall_beat: got %h/%b want %h/%b", m_data, m_last, e.d, e.l);
                    end
                end
            end
            if (s_valid && s_ready) begin
                model_accept(b, 1'b0);
                b_taken = 1'b1;
            end
            next_drive();
            if (b_taken) s_valid = 1'b0;
            if (b_taken && exp_q.size() == 0) break;
        end
        s_valid = 1'b0;
        total += 2;
        if (!b_taken) begin bad++; $display("FAIL stall_accept: got item not accepted want accepted"); end
        if (after !== 5) begin bad++; $display("FAIL stall_rest: got %0d beats want 5", after); end
    endtask

    task automatic test_random();
        beat_t e;
        int acc = 0, beats = 0, tl = 0;
        logic in_hs;
        logic prev_stall = 1'b0;
        logic [31:0] prev_d = 32'd0;
        logic prev_l = 1'b0;
        exp_q.delete();
        s_valid = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (acc == 1000 && exp_q.size() == 0) break;
            if (!s_valid && acc < 1000 && $urandom_range(1, 0) == 1) begin
                s_valid = 1'b1;
                s_data  = rand_item();
                s_last  = (acc % 100 == 99);
            end
            m_ready = ($urandom_range(1, 0) == 1);
            @(negedge clk);
            if (prev_stall) begin
                total++;
                if (!(m_valid === 1'b1 && m_data === prev_d && m_last === prev_l)) begin
                    bad++; $display("FAIL rand_hold: got %b/%h/%b want 1/%h/%b", m_valid, m_data, m_last, prev_d, prev_l);
                end
            end
            if (m_valid && m_ready) begin
                total++;
                beats++;
                if (m_last) tl++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rand_extra: got %h with nothing expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        bad++; $display("FAIL rand_beat: got %h/%b want %h/%b", m_data, m_last, e.d, e.l);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            in_hs = s_valid && s_ready;
            if (in_hs) begin
                model_accept(s_data, s_last);
                acc++;
            end
            next_drive();
            if (in_hs) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        total += 4;
        if (acc !== 1000) begin bad++; $display("FAIL rand_items: got %0d accepted want 1000", acc); end
        if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_drain: got %0d beats pending want 0", exp_q.size()); end
        if (beats !== 3000) begin bad++; $display("FAIL rand_beats: got %0d want 3000", beats); end
        if (tl !== 10) begin bad++; $display("FAIL rand_tlast: got %0d want 10", tl); end
    endtask

    task automatic test_reset_mid();
        logic [95:0] a, b;
        beat_t e;
        int   nb = 0;
        logic b_taken = 1'b0;
        a = rand_item();
        b = rand_item();
        exp_q.delete();
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = a; s_last = 1'b1;
        @(negedge clk);
        next_drive();
        s_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            next_drive();
        end
        // Item is now on its final lane; pull reset between edges
        total++;
        if (m_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre: got tvalid=%b want 1", m_valid); end
        rst_n = 1'b0;
        #1;
        total += 4;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid: got %b want 0", m_valid); end
        if (m_data !== 32'd0) begin bad++; $display("FAIL rstmid_tdata: got %h want 0", m_data); end
        if (m_last !== 1'b0) begin bad++; $display("FAIL rstmid_tlast: got %b want 0", m_last); end
        if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_sready: got %b want 1", s_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        next_drive();
        s_valid = 1'b1; s_data = b; s_last = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                total++;
                nb++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rstmid_stale: got %h with nothing expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        bad++; $display("FAIL rstmid_beat: got %h/%b want %h/%b", m_data, m_last, e.d, e.l);
                    end
                end
            end
            if (s_valid && s_ready) begin
                model_accept(b, 1'b0);
                b_taken = 1'b1;
            end
            next_drive();
            if (b_taken) s_valid = 1'b0;
            if (b_taken && exp_q.size() == 0) break;
        end
        s_valid = 1'b0;
        total++;
        if (nb !== 3) begin bad++; $display("FAIL rstmid_count: got %0d beats want 3", nb); end
    endtask

`ifdef CMS_DOWNSIZER_STATS_EN
    task automatic test_stats();
        beat_t e;
        int sent = 0, beats = 0, stalls = 0;
        logic [95:0] cur;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_drive();
        total += 3;
        if (item_count !== 32'd0) begin bad++; $display("FAIL stats_item_rst: got %0d want 0", item_count); end
        if (packet_count !== 32'd0) begin bad++; $display("FAIL stats_pkt_rst: got %0d want 0", packet_count); end
        if (stall_count !== 32'd0) begin bad++; $display("FAIL stats_stall_rst: got %0d want 0", stall_count); end
        exp_q.delete();
        cur = rand_item();
        for (int cyc = 0; cyc < 60; cyc++) begin
            s_valid = (sent < 4);
            s_data  = cur;
            s_last  = (sent == 3);
            m_ready = !(beats >= 4 && stalls < 5);
            @(negedge clk);
            if (m_valid && !m_ready) stalls++;
            if (m_valid && m_ready) begin
                total++;
                beats++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL stats_extra: got %h with nothing expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e.d || m_last !== e.l) begin
                        bad++; $display("FAIL stats_beat: got %h/%b want %h/%b", m_data, m_last, e.d, e.l);
                    end
                end
            end
            if (s_valid && s_ready) begin
                model_accept(cur, s_last);
                sent++;
                cur = rand_item();
            end
            next_drive();
            if (sent == 4 && exp_q.size() == 0) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        total += 4;
        if (beats !== 12) begin bad++; $display("FAIL stats_beats: got %0d want 12", beats); end
        if (item_count !== 32'd4) begin bad++; $display("FAIL stats_item: got %0d want 4", item_count); end
        if (packet_count !== 32'd1) begin bad++; $display("FAIL stats_pkt: got %0d want 1", packet_count); end
        if (stall_count !== 32'd5) begin bad++; $display("FAIL stats_stall: got %0d want 5", stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_mid();
`ifdef CMS_DOWNSIZER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
